// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package seg_pkg;

    localparam int SEG_DIGITS = 4;

    typedef logic [6:0] seg_pat_t;

    localparam seg_pat_t                SEG_OFF   = 7'b1111111;
    localparam logic [SEG_DIGITS-1:0]   ANODE_OFF = 4'b1111;

    localparam seg_pat_t HEX_PAT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble to active-low seven-segment pattern decoder.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_pat_t   pat
);

    assign pat = HEX_PAT[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 4-digit common-anode display scanner with blank gap and frame-aligned snapshot.
// Optional leading-zero blanking when SEG_LZ_BLANK_EN is defined.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int TICK_DIV = 100000,
    parameter int GAP_CYC  = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_seg,
    input  logic        page,
    output logic [3:0]  anode,
    output logic [6:0]  seg,
    output logic        frame_tick
);

    localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(GAP_CYC);

`ifdef SEG_LZ_BLANK_EN
    // A digit is lit when it or any digit above it is nonzero; digit 0 always lit.
    function automatic logic digit_lit(input logic [15:0] v, input logic [1:0] d);
        case (d)
            2'd0:    digit_lit = 1'b1;
            2'd1:    digit_lit = |v[15:4];
            2'd2:    digit_lit = |v[15:8];
            default: digit_lit = |v[15:12];
        endcase
    endfunction
`endif

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [15:0]      snap;
    logic             first_cyc;

    logic             wrap_p0;
    logic             snap_load_p0;
    logic             show_p0;
    logic             lit_p0;
    logic [15:0]      half_p0;
    logic [15:0]      snap_src_p0;
    logic [3:0]       nibble_p0;
    seg_pat_t         pat_p0;
    logic [3:0]       anode_p0;
    seg_pat_t         seg_p0;

    seg_hex_decode u_dec (
        .nibble (nibble_p0),
        .pat    (pat_p0)
    );

    // Stage p0: slot timing, snapshot select and next output pattern
    always_comb begin
        wrap_p0      = (cnt == CNT_LAST);
        snap_load_p0 = first_cyc || (wrap_p0 && (idx == 2'd3));
        half_p0      = page ? data_seg[31:16] : data_seg[15:0];
        // The first post-reset cycle displays the value being captured, not the cleared snap.
        snap_src_p0  = first_cyc ? half_p0 : snap;
        nibble_p0    = snap_src_p0[{idx, 2'b00} +: 4];
        show_p0      = (cnt >= GAP_END);
`ifdef SEG_LZ_BLANK_EN
        lit_p0       = digit_lit(snap_src_p0, idx);
`else
        lit_p0       = 1'b1;
`endif
        anode_p0     = ANODE_OFF;
        seg_p0       = SEG_OFF;
        if (show_p0 && lit_p0) begin
            anode_p0 = ~(4'b0001 << idx);
            seg_p0   = pat_p0;
        end
    end

    // Stage p1: registered state and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            snap       <= '0;
            first_cyc  <= 1'b1;
            anode      <= ANODE_OFF;
            seg        <= SEG_OFF;
            frame_tick <= 1'b0;
        end else begin
            cnt        <= wrap_p0 ? '0 : cnt + 1'b1;
            if (wrap_p0)
                idx    <= idx + 2'd1;
            if (snap_load_p0)
                snap   <= half_p0;
            first_cyc  <= 1'b0;
            anode      <= anode_p0;
            seg        <= seg_p0;
            frame_tick <= snap_load_p0;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with TICK_DIV=8, GAP_CYC=2; follows SEG_LZ_BLANK_EN if defined.
module tb_seg_scan_ctrl;

    localparam int TICK = 8;
    localparam int GAP  = 2;

    localparam logic [6:0] HEX_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_seg = 32'h0;
    logic        page = 1'b0;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        frame_tick;

    int checks   = 0;
    int failures = 0;
    int cur      = 0;

    seg_scan_ctrl #(.TICK_DIV(TICK), .GAP_CYC(GAP)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_seg   (data_seg),
        .page       (page),
        .anode      (anode),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_lit(input logic [15:0] v, input int d);
`ifdef SEG_LZ_BLANK_EN
        if (d == 0) return 1'b1;
        return (v >> (4 * d)) != 16'h0;
`else
        return (v != v + 16'h1) || (d >= 0);
`endif
    endfunction

    // Reference model: outputs derived from the cycle count since reset release.
    logic        armed = 1'b0;
    int          k = 0;
    int          cyc = 0;
    logic [15:0] msnap = '0;
    logic [3:0]  exp_anode;
    logic [6:0]  exp_seg;
    logic        exp_tick;
    logic [3:0]  last_lit;
    int          off_run = 0;
    int          tick_n = 0;
    int          last_tick = 0;

    always @(negedge clk) begin
        logic [15:0] half;
        int pos, dig;
        bit shown;
        cyc++;
        if (armed) begin
            chk("anode", {28'h0, anode}, {28'h0, exp_anode});
            chk("seg", {25'h0, seg}, {25'h0, exp_seg});
            chk("frame_tick", {31'h0, frame_tick}, {31'h0, exp_tick});
            chk("onehot_anode", ($countones(~anode) <= 1) ? 32'd1 : 32'd0, 32'd1);
            if (anode != 4'hF) begin
                if (last_lit != 4'hF && anode != last_lit)
                    chk("gap_len", (off_run >= GAP) ? 32'd1 : 32'd0, 32'd1);
                last_lit = anode;
                off_run  = 0;
            end else begin
                off_run++;
            end
            if (frame_tick === 1'b1) begin
                tick_n++;
                if (tick_n >= 3)
                    chk("tick_period", cyc - last_tick, 4 * TICK);
                last_tick = cyc;
            end
        end
        if (rst) begin
            exp_anode = 4'hF;
            exp_seg   = 7'h7F;
            exp_tick  = 1'b0;
            k         = 0;
            msnap     = '0;
            armed     = 1'b1;
            last_lit  = 4'hF;
            off_run   = 0;
            tick_n    = 0;
        end else if (armed) begin
            half = page ? data_seg[31:16] : data_seg[15:0];
            if (k == 0) msnap = half;
            pos       = k % TICK;
            dig       = (k / TICK) % 4;
            exp_tick  = (k == 0) || (k % (4 * TICK) == 4 * TICK - 1);
            shown     = (pos >= GAP) && m_lit(msnap, dig);
            exp_anode = shown ? ~(4'b0001 << dig) : 4'hF;
            exp_seg   = shown ? HEX_TAB[(msnap >> (4 * dig)) & 16'hF] : 7'h7F;
            if (k % (4 * TICK) == 4 * TICK - 1) msnap = half;
            k++;
        end
    end

    task automatic goto(input int c);
        while (cur < c) begin
            @(posedge clk);
            #1;
            cur++;
        end
    endtask

    task automatic look(input int c);
        goto(c);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        cur = 0;
    endtask

    initial begin
        // Reset release with 1234 on page 0
        data_seg = 32'h0000_1234;
        page     = 1'b0;
        do_reset(3);
        look(0);
        chk("rst_anode", {28'h0, anode}, 32'hF);
        chk("rst_seg", {25'h0, seg}, 32'h7F);
        chk("rst_tick", {31'h0, frame_tick}, 32'h0);
        look(1);
        chk("c1_tick", {31'h0, frame_tick}, 32'h1);
        chk("c1_anode", {28'h0, anode}, 32'hF);
        look(2);
        chk("c2_tick", {31'h0, frame_tick}, 32'h0);
        chk("c2_anode", {28'h0, anode}, 32'hF);
        look(3);
        chk("d0_anode", {28'h0, anode}, 32'hE);
        chk("d0_seg", {25'h0, seg}, {25'h0, 7'b0011001});
        look(8);
        chk("d0_last", {28'h0, anode}, 32'hE);
        look(9);
        chk("d1_gap", {28'h0, anode}, 32'hF);
        look(11);
        chk("d1_anode", {28'h0, anode}, 32'hD);
        chk("d1_seg", {25'h0, seg}, {25'h0, 7'b0110000});
        look(19);
        chk("d2_anode", {28'h0, anode}, 32'hB);
        chk("d2_seg", {25'h0, seg}, {25'h0, 7'b0100100});
        look(27);
        chk("d3_anode", {28'h0, anode}, 32'h7);
        chk("d3_seg", {25'h0, seg}, {25'h0, 7'b1111001});
        look(32);
        chk("f1_tick", {31'h0, frame_tick}, 32'h1);
        goto(110);

        // Data change mid-frame during digit 1
        data_seg = 32'h0000_1234;
        do_reset(2);
        goto(12);
        data_seg = 32'h0000_5678;
        look(19);
        chk("old_d2_seg", {25'h0, seg}, {25'h0, 7'b0100100});
        look(27);
        chk("old_d3_seg", {25'h0, seg}, {25'h0, 7'b1111001});
        look(32);
        chk("new_tick", {31'h0, frame_tick}, 32'h1);
        look(35);
        chk("new_d0_anode", {28'h0, anode}, 32'hE);
        chk("new_d0_seg", {25'h0, seg}, {25'h0, 7'b0000000});
        look(43);
        chk("new_d1_seg", {25'h0, seg}, {25'h0, 7'b1111000});
        goto(70);

        // One-cycle reset during SHOW of digit 2
        data_seg = 32'h0000_1234;
        do_reset(2);
        goto(20);
        rst = 1'b1;
        goto(21);
        rst = 1'b0;
        cur = 0;
        look(0);
        chk("mid_rst_anode", {28'h0, anode}, 32'hF);
        chk("mid_rst_seg", {25'h0, seg}, 32'h7F);
        look(1);
        chk("mid_rst_tick", {31'h0, frame_tick}, 32'h1);
        look(3);
        chk("restart_anode", {28'h0, anode}, 32'hE);
        chk("restart_seg", {25'h0, seg}, {25'h0, 7'b0011001});
        goto(40);

        // Upper page ABCD
        data_seg = 32'hABCD_0000;
        page     = 1'b1;
        do_reset(2);
        look(3);
        chk("pg_d0_seg", {25'h0, seg}, {25'h0, 7'b0100001});
        look(11);
        chk("pg_d1_seg", {25'h0, seg}, {25'h0, 7'b1000110});
        look(19);
        chk("pg_d2_seg", {25'h0, seg}, {25'h0, 7'b0000011});
        look(27);
        chk("pg_d3_seg", {25'h0, seg}, {25'h0, 7'b0001000});
        goto(100);

        // Leading-zero cases: 7 and 0
        data_seg = 32'h0000_0007;
        page     = 1'b0;
        do_reset(2);
        look(3);
        chk("lz7_d0_anode", {28'h0, anode}, 32'hE);
        chk("lz7_d0_seg", {25'h0, seg}, {25'h0, 7'b1111000});
        look(11);
`ifdef SEG_LZ_BLANK_EN
        chk("lz7_d1_anode", {28'h0, anode}, 32'hF);
`else
        chk("lz7_d1_anode", {28'h0, anode}, 32'hD);
        chk("lz7_d1_seg", {25'h0, seg}, {25'h0, 7'b1000000});
`endif
        goto(70);
        data_seg = 32'h0;
        do_reset(2);
        look(3);
        chk("z_d0_seg", {25'h0, seg}, {25'h0, 7'b1000000});
        look(27);
`ifdef SEG_LZ_BLANK_EN
        chk("z_d3_anode", {28'h0, anode}, 32'hF);
`else
        chk("z_d3_anode", {28'h0, anode}, 32'h7);
`endif
        goto(70);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
